// File: rtl/floor_request_latch.sv
// Request stage for the two-car controller: synchronises and debounces raw hall/car
// buttons, latches presses, and clears a floor's requests after a car has dwelt there.
module floor_request_latch #(
   parameter int unsigned DEBOUNCE_CYCLES = 4,
   parameter int unsigned SERVICE_CYCLES  = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [11:0] hall_buttons,
   input  logic [11:0] car_buttons,
   input  logic [7:0]  half_elevatorPositions,
   input  logic [1:0]  at_stop,
   output logic [11:0] FloorsRequested,
   output logic [11:0] FloorDestinations,
   output logic [1:0]  request_pending,
   output logic [11:0] service_clear
);

   localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int unsigned SW = $clog2(SERVICE_CYCLES + 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_DWELL,
      S_DONE
   } svc_e;

   logic [23:0]   raw;
   logic [23:0]   sync1_q, sync2_q;
   logic [23:0]   deb_q, deb_d, debp_q;
   logic [DW-1:0] dcnt_q [24];
   logic [DW-1:0] dcnt_d [24];
   logic [23:0]   set_vec;

   logic [11:0]   fr_q, fr_d, fd_q, fd_d;
   logic [11:0]   clr_mask;

   svc_e          st_q   [2];
   svc_e          st_d   [2];
   logic [2:0]    flr_q  [2];
   logic [2:0]    flr_d  [2];
   logic [SW-1:0] scnt_q [2];
   logic [SW-1:0] scnt_d [2];
   logic [3:0]    pos    [2];
   logic [1:0]    valid;
   logic [1:0]    here;
   logic [1:0]    clr;

   assign raw    = {car_buttons, hall_buttons};
   assign pos[0] = half_elevatorPositions[7:4];
   assign pos[1] = half_elevatorPositions[3:0];

   always_comb begin
      for (int unsigned i = 0; i < 24; i++) begin
         deb_d[i]  = deb_q[i];
         dcnt_d[i] = '0;
         if (sync2_q[i] != deb_q[i]) begin
            if (dcnt_q[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
               deb_d[i] = sync2_q[i];
            end else begin
               dcnt_d[i] = dcnt_q[i] + 1'b1;
            end
         end
      end
   end

   assign set_vec = deb_q & ~debp_q;

   always_comb begin
      for (int unsigned c = 0; c < 2; c++) begin
         valid[c]  = (pos[c][0] == 1'b0) && (pos[c] <= 4'd10);
         here[c]   = at_stop[c] & valid[c];
         st_d[c]   = st_q[c];
         flr_d[c]  = flr_q[c];
         scnt_d[c] = scnt_q[c];
         clr[c]    = 1'b0;
         case (st_q[c])
            S_IDLE: begin
               if (here[c]) begin
                  st_d[c]   = S_DWELL;
                  flr_d[c]  = pos[c][3:1];
                  scnt_d[c] = SW'(1);
               end
            end
            S_DWELL: begin
               // The full dwell has already been counted, so the clear fires regardless of this cycle's inputs.
               if (scnt_q[c] == SW'(SERVICE_CYCLES)) begin
                  clr[c]    = 1'b1;
                  st_d[c]   = S_DONE;
                  scnt_d[c] = '0;
               end else if (here[c] && (pos[c][3:1] == flr_q[c])) begin
                  scnt_d[c] = scnt_q[c] + 1'b1;
               end else begin
                  st_d[c]   = S_IDLE;
                  scnt_d[c] = '0;
               end
            end
            S_DONE: begin
               if (!here[c] || (pos[c][3:1] != flr_q[c])) begin
                  st_d[c] = S_IDLE;
               end
            end
            default: begin
               st_d[c]   = S_IDLE;
               scnt_d[c] = '0;
            end
         endcase
      end
   end

   always_comb begin
      clr_mask = '0;
      if (clr[0]) clr_mask = clr_mask | (12'd1 << flr_q[0]);
      if (clr[1]) clr_mask = clr_mask | (12'd64 << flr_q[1]);
      fr_d = (fr_q | set_vec[11:0])  & ~clr_mask;
      fd_d = (fd_q | set_vec[23:12]) & ~clr_mask;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         sync1_q <= '0;
         sync2_q <= '0;
         deb_q   <= '0;
         debp_q  <= '0;
         fr_q    <= '0;
         fd_q    <= '0;
         for (int unsigned i = 0; i < 24; i++) dcnt_q[i] <= '0;
         for (int unsigned c = 0; c < 2; c++) begin
            st_q[c]   <= S_IDLE;
            flr_q[c]  <= '0;
            scnt_q[c] <= '0;
         end
      end else begin
         sync1_q <= raw;
         sync2_q <= sync1_q;
         deb_q   <= deb_d;
         debp_q  <= deb_q;
         fr_q    <= fr_d;
         fd_q    <= fd_d;
         for (int unsigned i = 0; i < 24; i++) dcnt_q[i] <= dcnt_d[i];
         for (int unsigned c = 0; c < 2; c++) begin
            st_q[c]   <= st_d[c];
            flr_q[c]  <= flr_d[c];
            scnt_q[c] <= scnt_d[c];
         end
      end
   end

   assign FloorsRequested    = fr_q;
   assign FloorDestinations  = fd_q;
   assign request_pending[0] = |(fr_q[5:0]  | fd_q[5:0]);
   assign request_pending[1] = |(fr_q[11:6] | fd_q[11:6]);
   assign service_clear      = clr_mask & (fr_q | fd_q);

endmodule
